mux_4_1_rr_arbiter: RTL and testbench
=====================================

MUX_4_1_RR_ARBITER -- requirements
Module: mux_4_1_rr_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the data width of every data port.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous, active-low (rst == 0 at a rising clk edge resets).
REQ-004 The block SHALL have port req_vld, input, 4, where bit i means requester i offers data.
REQ-005 The block SHALL have ports d0, d1, d2, d3, input, W each, the requester data words.
REQ-006 The block SHALL have port req_rdy, output, 4, where bit i means requester i's word is taken this cycle.
REQ-007 The block SHALL have port out_vld, output, 1, meaning out_data/out_src hold a valid word.
REQ-008 The block SHALL have port out_rdy, input, 1, meaning the consumer accepts the output word this cycle.
REQ-009 The block SHALL have port out_data, output, W, the selected word (registered).
REQ-010 The block SHALL have port out_src, output, 2, the index of the requester that supplied out_data (registered).

Function
REQ-011 Internal state SHALL be: a one-entry output register (states EMPTY: out_vld=0; FULL: out_vld=1) and a 2-bit last_grant pointer.
REQ-012 accept SHALL be (out_vld == 0) or (out_rdy == 1), i.e. the register is empty or drains this cycle.
REQ-013 Grant SHALL be round-robin: search req_vld from index last_grant+1 upward, modulo 4; the first set bit wins.
REQ-014 req_rdy SHALL be combinational, one-hot or zero: req_rdy[g] = accept and req_vld[g], for the granted index g only; all other bits 0.
REQ-015 req_rdy SHALL be all zero when no req_vld bit is set or accept is 0.
REQ-016 A transfer from requester g (req_vld[g] and req_rdy[g]) SHALL, at the next edge, load out_data = d_g, load out_src = g, set out_vld = 1, and set last_grant = g.
REQ-017 Data selection SHALL be equivalent to a 4:1 mux: index 0 -> d0, 1 -> d1, 2 -> d2, 3 -> d3.
REQ-018 Latency SHALL be one cycle from input transfer to out_vld; throughput SHALL be one word per cycle when out_rdy is held 1.
REQ-019 FULL with out_rdy = 1 and no transfer SHALL go to EMPTY (out_vld = 0); out_data/out_src SHALL hold their old values.
REQ-020 FULL with out_rdy = 1 and a simultaneous transfer SHALL stay FULL and load the new word (drain and refill in the same cycle).
REQ-021 FULL with out_rdy = 0 SHALL hold out_vld, out_data, out_src and last_grant unchanged, with req_rdy = 0.
REQ-022 last_grant SHALL change only on a transfer; it SHALL wrap from 3 to 0.
REQ-023 The arbiter SHALL not starve any requester: a continuously asserted req_vld[i] SHALL be granted within 4 transfers.
REQ-024 Changes on req_vld or d* while accept = 0 SHALL have no effect on state.

Reset
REQ-025 When rst == 0 at a clk edge, the block SHALL set out_vld = 0, out_data = 0, out_src = 0, and last_grant = 3, so that requester 0 has first priority.
REQ-026 While rst == 0, req_rdy SHALL be forced to 0; reset asserted mid-transfer SHALL discard the pending word, and no transfer SHALL be counted.
REQ-027 The first edge with rst == 1 SHALL behave as EMPTY with last_grant = 3.

Verification
REQ-028 Reset then idle: rst=0 for 2 cycles, then req_vld=0000 -> out_vld=0, out_data=0, out_src=0, req_rdy=0000 every cycle.
REQ-029 Single requester: req_vld=0100, d2=4'hA, out_rdy=1 -> req_rdy=0100; next cycle out_vld=1, out_data=A, out_src=2.
REQ-030 Round-robin: after reset, req_vld=1111 held, out_rdy=1, d0..d3=1,2,3,4 -> out_src sequence 0,1,2,3,0 and out_data 1,2,3,4,1, one word per cycle.
REQ-031 Backpressure: FULL with out_data=5 and out_rdy=0 for 3 cycles while req_vld=1111 -> req_rdy=0000 and out_data=5 stable; out_rdy=1 -> next word accepted in the same cycle (REQ-020).
REQ-032 Skip and wrap: last_grant=2, req_vld=1001 -> grant 3; then req_vld=1001 again -> grant 0.
REQ-033 Reset mid-stream: FULL with out_src=1, rst=0 for one edge -> out_vld=0, out_data=0, out_src=0; with req_vld=1111 after release, the first grant is 0.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter: round-robin 4:1 mux into a one-entry registered output stage
module mux_4_1_rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_vld,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   req_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t st;
  logic [1:0] last_grant, p1, p2, p3, g;
  logic accept, xfer;
  logic [W-1:0] sel;
  assign out_vld = (st == FULL);
  assign accept = !out_vld || out_rdy;
  assign p1 = last_grant + 2'd1;
  assign p2 = last_grant + 2'd2;
  assign p3 = last_grant + 2'd3;
  // search starts just past the last winner; falls back to last_grant itself
  always_comb begin
    g = req_vld[p1] ? p1 : req_vld[p2] ? p2 : req_vld[p3] ? p3 : last_grant;
    sel = (g == 2'd0) ? d0 : (g == 2'd1) ? d1 : (g == 2'd2) ? d2 : d3;
  end
  assign xfer = rst && accept && (|req_vld);
  assign req_rdy = xfer ? (4'b0001 << g) : 4'b0000;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= EMPTY;
      out_data <= '0;
      out_src <= 2'd0;
      last_grant <= 2'd3;
    end else if (xfer) begin
      st <= FULL;
      out_data <= sel;
      out_src <= g;
      last_grant <= g;
    end else if (out_rdy) begin
      st <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb_mux_4_1_rr_arbiter: directed and random stimulus against a behavioural round-robin model
module tb_mux_4_1_rr_arbiter;
  logic clk = 0;
  logic rst;
  logic [3:0] req_vld, req_rdy;
  logic [3:0] d0, d1, d2, d3, out_data;
  logic out_vld, out_rdy;
  logic [1:0] out_src;
  int n_cmp = 0, n_err = 0;
  bit m_vld;
  int m_data, m_src, m_last;
  int wait_cnt [4];

  always #5 clk = ~clk;

  mux_4_1_rr_arbiter #(.W(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_src(out_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] v, input int a, input int b,
                      input int c, input int e, input bit o);
    int dd [4];
    int g;
    bit acc, x;
    @(negedge clk);
    rst = r; req_vld = v; out_rdy = o;
    d0 = 4'(a); d1 = 4'(b); d2 = 4'(c); d3 = 4'(e);
    dd[0] = a & 15; dd[1] = b & 15; dd[2] = c & 15; dd[3] = e & 15;
    #1;
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
    acc = !m_vld || o;
    x = r && acc && (g >= 0);
    chk("req_rdy", req_rdy, x ? (32'd1 << g) : 32'd0);
    chk("out_vld", out_vld, m_vld);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    if (x)
      for (int i = 0; i < 4; i++) begin
        if (i == g || !v[i]) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          chk("starve", wait_cnt[i] <= 3, 1);
        end
      end
    if (!r) for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    @(posedge clk);
    if (!r) begin
      m_vld = 0; m_data = 0; m_src = 0; m_last = 3;
    end else if (x) begin
      m_vld = 1; m_data = dd[g]; m_src = g; m_last = g;
    end else if (o) m_vld = 0;
  endtask

  initial begin
    m_vld = 0; m_data = 0; m_src = 0; m_last = 3;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    rst = 0; req_vld = 0; out_rdy = 0; d0 = 0; d1 = 0; d2 = 0; d3 = 0;
    @(posedge clk);
    // reset then idle
    step(0, 4'b0000, 0, 0, 0, 0, 1);
    step(0, 4'b1111, 1, 2, 3, 4, 1);
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 0, 0, 0, 0, 1);
    // single requester
    step(1, 4'b0100, 0, 0, 10, 0, 1);
    #2;
    chk("single_data", out_data, 4'hA);
    chk("single_src", out_src, 2);
    // round-robin sequence from reset
    step(0, 4'b0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b1111, 1, 2, 3, 4, 1);
      #2;
      chk("rr_src", out_src, i % 4);
      chk("rr_data", out_data, (i % 4) + 1);
    end
    // backpressure with out_data=5
    step(1, 4'b0010, 0, 5, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b1111, 7, 8, 9, 6, 0);
      #2;
      chk("bp_data", out_data, 5);
      chk("bp_vld", out_vld, 1);
    end
    step(1, 4'b1111, 7, 8, 9, 6, 1);
    #2;
    chk("bp_refill_src", out_src, 2);
    // skip and wrap from last_grant=2
    step(1, 4'b1001, 1, 1, 1, 3, 1);
    #2;
    chk("wrap_g3", out_src, 3);
    step(1, 4'b1001, 12, 1, 1, 3, 1);
    #2;
    chk("wrap_g0", out_src, 0);
    // reset mid-stream while FULL with out_src=1
    step(1, 4'b0010, 0, 9, 0, 0, 1);
    step(0, 4'b1111, 1, 2, 3, 4, 0);
    #2;
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    step(1, 4'b1111, 1, 2, 3, 4, 1);
    #2;
    chk("rst_first", out_src, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(49) != 0, 4'($urandom), $urandom, $urandom, $urandom,
           $urandom, $urandom_range(3) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
